pipe_hazard_ctrl: RTL

Scoreboard-based hazard and issue controller for the 5-stage pipeline (FETCH → DEC → EXE → MEM → WB), which has no forwarding. It tracks in-flight register writes between decode-issue and register-file write. It stalls FETCH/DEC and injects EXE bubbles on RAW hazards or scoreboard overflow. It also provides a drain/halt handshake and a hazard-stall statistics counter.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 15 +
 rtl/pipe_hazard_ctrl_if.sv | 49 ++++
 rtl/pipe_hazard_ctrl_sb_counter.sv | 41 ++++
 rtl/pipe_hazard_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/issue controller.
// Imported by the interface, the per-register counter and the top level.
package pipe_ctrl_pkg;

    localparam int NREG_DEF = 16;
    localparam int AW_DEF   = 4;
    localparam int REG0     = 0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/writeback/control bundle between the pipeline (master) and the
// hazard controller (slave); the controller's FSM state is exported for debug.
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF,
    parameter int SCW  = 16
);
    // Strobe semantics: dec_valid marks a real instruction in DEC, and it
    // advances only in a cycle where issue = 1; stall_fd/bubble_ex are the
    // hold/kill side of that same decision.  wb_wen is a one-cycle retire
    // strobe with no back-pressure.
    logic            dec_valid;
    logic [AW-1:0]   dec_rs1;
    logic [AW-1:0]   dec_rs2;
    logic            dec_uses_rs1;
    logic            dec_uses_rs2;
    logic            dec_needs_wb;
    logic [AW-1:0]   dec_rd;
    logic            wb_wen;
    logic [AW-1:0]   wb_addr;
    logic            drain_req;
    logic            stats_clr;

    logic            stall_fd;
    logic            bubble_ex;
    logic            issue;
    logic [NREG-1:0] busy_mask;
    logic            drained;
    logic [SCW-1:0]  stall_cnt;
    logic            err_underflow;
    ctrl_state_t     state;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
               dec_needs_wb, dec_rd, wb_wen, wb_addr, drain_req, stats_clr,
        input  stall_fd, bubble_ex, issue, busy_mask, drained, stall_cnt,
               err_underflow, state
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
               dec_needs_wb, dec_rd, wb_wen, wb_addr, drain_req, stats_clr,
        output stall_fd, bubble_ex, issue, busy_mask, drained, stall_cnt,
               err_underflow, state
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sb_counter.sv
// Pending-write counter for one architectural register: counts writes issued
// from DEC that have not yet reached the register file.
module sb_counter #(
    parameter int CW       = 3,
    parameter int MAX_PEND = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          nonzero,
    output logic          full,
    output logic          underflow
);

    logic [CW-1:0] count_n;

    assign nonzero   = (count != '0);
    assign full      = (count == CW'(MAX_PEND));
    // A simultaneous issue and retire cancel, so only a lone retire can underflow.
    assign underflow = dec && !inc && !nonzero;

    always_comb begin
        count_n = count;
        if (inc && !dec && !full) begin
            count_n = count + CW'(1);
        end else if (dec && !inc && nonzero) begin
            count_n = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_n;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard hazard/issue controller for a 5-stage pipeline without forwarding:
// RAW and overflow stalls, drain/halt handshake and a hazard-stall counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NREG     = NREG_DEF,
    parameter int AW       = AW_DEF,
    parameter int MAX_PEND = 4,
    parameter int CW       = 3,
    parameter int SCW      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_hazard_ctrl_if.slave bus
);

    localparam logic [AW-1:0] R0 = AW'(REG0);

    logic [NREG-1:0][CW-1:0] pend;
    logic [NREG-1:0]         nz_vec;
    logic [NREG-1:0]         full_vec;
    logic [NREG-1:0]         uf_vec;

    logic        src1_hz;
    logic        src2_hz;
    logic        dst_hz;
    logic        hazard;
    logic        all_idle;
    logic        stall_c;
    logic        bubble_c;
    logic        issue_c;
    logic        cnt_en;

    ctrl_state_t     state;
    ctrl_state_t     state_n;
    logic [SCW-1:0]  stall_cnt_q;
    logic            err_q;

    // r0 is hard-wired: never pending, never full, never underflows.
    assign pend[0]     = '0;
    assign nz_vec[0]   = 1'b0;
    assign full_vec[0] = 1'b0;
    assign uf_vec[0]   = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_sb
        logic inc_r;
        logic dec_r;

        assign inc_r = issue_c && bus.dec_needs_wb && (bus.dec_rd == AW'(r));
        assign dec_r = bus.wb_wen && (bus.wb_addr == AW'(r));

        sb_counter #(
            .CW       (CW),
            .MAX_PEND (MAX_PEND)
        ) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (inc_r),
            .dec       (dec_r),
            .count     (pend[r]),
            .nonzero   (nz_vec[r]),
            .full      (full_vec[r]),
            .underflow (uf_vec[r])
        );
    end

    // No bypass: a source stays blocked through its retire edge.
    assign src1_hz = bus.dec_uses_rs1 && (bus.dec_rs1 != R0) && nz_vec[bus.dec_rs1];
    assign src2_hz = bus.dec_uses_rs2 && (bus.dec_rs2 != R0) && nz_vec[bus.dec_rs2];
    assign dst_hz  = bus.dec_needs_wb && (bus.dec_rd != R0) && full_vec[bus.dec_rd];
    assign hazard  = bus.dec_valid && (src1_hz || src2_hz || dst_hz);

    always_comb begin
        all_idle = 1'b1;
        for (int r = 0; r < NREG; r++) begin
            if (pend[r] != '0) begin
                all_idle = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        issue_c  = 1'b0;
        unique case (state)
            RUN: begin
                stall_c  = hazard;
                bubble_c = hazard;
                issue_c  = bus.dec_valid && !hazard;
                if (bus.drain_req) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (!bus.drain_req) begin
                    state_n = RUN;
                end else if (all_idle) begin
                    state_n = HALT;
                end
            end
            HALT: begin
                if (!bus.drain_req) begin
                    state_n = RUN;
                end
            end
            default: state_n = RUN;
        endcase
        // Hold the front end and kill EXE for as long as reset is asserted.
        if (!rst_n) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            issue_c  = 1'b0;
        end
    end

    // A stall in the cycle drain is requested belongs to the drain, not to hazards.
    assign cnt_en = (state == RUN) && hazard && !bus.drain_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (bus.stats_clr) begin
            stall_cnt_q <= '0;
        end else if (cnt_en && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + SCW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (|uf_vec) begin
            err_q <= 1'b1;
        end
    end

    assign bus.stall_fd      = stall_c;
    assign bus.bubble_ex     = bubble_c;
    assign bus.issue         = issue_c;
    assign bus.busy_mask     = nz_vec;
    assign bus.drained       = (state == HALT);
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.err_underflow = err_q;
    assign bus.state         = state;

endmodule
